// File: rtl/pipe_ctrl_pkg.sv
// Shared pipeline-control definitions: bus widths, hold codes and controller states.
package pipe_ctrl_pkg;
  localparam int InstAddrBus = 32;
  typedef logic [InstAddrBus-1:0] addr_t;

  typedef enum logic [2:0] {
    HOLD_NONE = 3'd0,
    HOLD_PC   = 3'd1,
    HOLD_IF   = 3'd2,
    HOLD_ID   = 3'd3
  } hold_e;

  typedef enum logic [1:0] {
    S_RUN,
    S_FLUSH,
    S_HALTING,
    S_HALTED
  } state_e;
endpackage

// File: rtl/pipe_ctrl_if.sv
// Pipeline-control bundle: redirect/hold requests in, hold code and PC redirect out.
interface pipe_ctrl_if;
  import pipe_ctrl_pkg::*;

  logic        jump_flag_i;
  addr_t       jump_addr_i;
  logic        hold_ex_i;
  logic        hold_rib_i;
  logic        int_assert_i;
  addr_t       int_addr_i;
  logic        halt_req_i;
  logic [2:0]  hold_flag_o;
  logic        jump_flag_o;
  addr_t       jump_addr_o;
  logic        halted_o;
  logic [31:0] hold_cnt_o;

  modport master (
    output jump_flag_i, jump_addr_i, hold_ex_i, hold_rib_i, int_assert_i, int_addr_i, halt_req_i,
    input  hold_flag_o, jump_flag_o, jump_addr_o, halted_o, hold_cnt_o
  );

  modport slave (
    input  jump_flag_i, jump_addr_i, hold_ex_i, hold_rib_i, int_assert_i, int_addr_i, halt_req_i,
    output hold_flag_o, jump_flag_o, jump_addr_o, halted_o, hold_cnt_o
  );
endinterface

// File: rtl/sat_cnt.sv
// Saturating up-counter with enable and synchronous clear; sticks at all-ones.
module sat_cnt #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] q
);
  always_ff @(posedge clk) begin
    if (clr)                q <= '0;
    else if (en && q != '1) q <= q + W'(1);
  end
endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline controller: redirect strobes, hold codes, flush timing and debug halt/drain.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int DRAIN_CYC = 4,
  parameter int FLUSH_CYC = 1
) (
  input logic       clk,
  input logic       rst,
  pipe_ctrl_if.slave bus
);
  localparam logic [31:0] DRAIN_LD  = 32'(DRAIN_CYC);
  localparam logic [31:0] FLUSH_LD  = 32'(FLUSH_CYC);
  localparam state_e      REDIR_NXT = (FLUSH_CYC == 0) ? S_RUN : S_FLUSH;

  state_e      state;
  logic [31:0] cnt;
  logic        redir;
  hold_e       hold;

  // A halted core ignores every redirect source.
  assign redir = (state != S_HALTED) && (bus.int_assert_i || bus.jump_flag_i);

  always_comb begin
    hold            = HOLD_NONE;
    bus.jump_flag_o = 1'b0;
    bus.jump_addr_o = '0;
    if (!rst) begin
      if (redir) begin
        hold            = HOLD_ID;
        bus.jump_flag_o = 1'b1;
        bus.jump_addr_o = bus.int_assert_i ? bus.int_addr_i : bus.jump_addr_i;
      end else begin
        case (state)
          S_RUN:     hold = bus.hold_ex_i ? HOLD_ID : (bus.hold_rib_i ? HOLD_PC : HOLD_NONE);
          S_FLUSH:   hold = HOLD_ID;
          S_HALTING: hold = bus.hold_ex_i ? HOLD_ID : HOLD_PC;
          default:   hold = HOLD_ID;
        endcase
      end
    end
  end

  assign bus.hold_flag_o = hold;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_RUN;
      cnt          <= '0;
      bus.halted_o <= 1'b0;
    end else begin
      case (state)
        S_RUN, S_FLUSH: begin
          // FLUSH exit falls through to the same halt check as RUN.
          if (redir) begin
            state <= REDIR_NXT;
            cnt   <= FLUSH_LD;
          end else if (state == S_FLUSH && cnt > 32'd1) begin
            cnt <= cnt - 32'd1;
          end else if (bus.halt_req_i) begin
            state <= S_HALTING;
            cnt   <= DRAIN_LD;
          end else begin
            state <= S_RUN;
            cnt   <= '0;
          end
        end
        S_HALTING: begin
          if (!bus.halt_req_i) begin
            state <= S_RUN;
            cnt   <= '0;
          end else if (redir) begin
            cnt <= DRAIN_LD;
          end else if (!bus.hold_ex_i) begin
            if (cnt <= 32'd1) begin
              state        <= S_HALTED;
              cnt          <= '0;
              bus.halted_o <= 1'b1;
            end else begin
              cnt <= cnt - 32'd1;
            end
          end
        end
        S_HALTED: begin
          if (!bus.halt_req_i) begin
            state        <= S_RUN;
            bus.halted_o <= 1'b0;
          end
        end
        default: state <= S_RUN;
      endcase
    end
  end

  sat_cnt #(.W(32)) u_hold_cnt (
    .clk (clk),
    .clr (rst),
    .en  (hold != HOLD_NONE),
    .q   (bus.hold_cnt_o)
  );
endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: directed scenarios then random traffic against a cycle model.
module tb_pipe_ctrl;
  localparam int DRAIN = 4;
  localparam int FLUSH = 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pipe_ctrl_if bus();
  pipe_ctrl #(.DRAIN_CYC(DRAIN), .FLUSH_CYC(FLUSH)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic [2:0]  hold;
    logic        jflag;
    logic [31:0] addr;
    logic        halted;
    logic [31:0] cnt;
  } exp_t;

  typedef enum {M_RUN, M_FLUSH, M_DRAIN, M_HALT} mode_t;

  exp_t        sb[$];
  exp_t        last;
  mode_t       m;
  int unsigned left;
  logic [31:0] m_cnt;
  int          n_chk = 0;
  int          n_fail = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  // Expected outputs for the current inputs from the model's view of the controller.
  function automatic exp_t model_out();
    exp_t e;
    e.hold = 3'd0; e.jflag = 1'b0; e.addr = 32'd0;
    e.halted = (m == M_HALT);
    e.cnt = m_cnt;
    if (rst) return e;
    if (m != M_HALT && (bus.int_assert_i || bus.jump_flag_i)) begin
      e.jflag = 1'b1;
      e.addr  = bus.int_assert_i ? bus.int_addr_i : bus.jump_addr_i;
      e.hold  = 3'd3;
    end else begin
      case (m)
        M_RUN:   e.hold = bus.hold_ex_i ? 3'd3 : (bus.hold_rib_i ? 3'd1 : 3'd0);
        M_FLUSH: e.hold = 3'd3;
        M_DRAIN: e.hold = bus.hold_ex_i ? 3'd3 : 3'd1;
        default: e.hold = 3'd3;
      endcase
    end
    return e;
  endfunction

  task automatic model_edge();
    bit redir;
    redir = (m != M_HALT) && (bus.int_assert_i || bus.jump_flag_i);
    if (rst) begin
      m = M_RUN; left = 0; m_cnt = 32'd0;
      return;
    end
    if (last.hold != 3'd0 && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
    case (m)
      M_RUN, M_FLUSH: begin
        if (redir) begin
          m = (FLUSH == 0) ? M_RUN : M_FLUSH;
          left = FLUSH;
        end else if (m == M_FLUSH && left > 1) left--;
        else if (bus.halt_req_i) begin m = M_DRAIN; left = DRAIN; end
        else m = M_RUN;
      end
      M_DRAIN: begin
        if (!bus.halt_req_i) m = M_RUN;
        else if (redir) left = DRAIN;
        else if (!bus.hold_ex_i) begin
          if (left <= 1) m = M_HALT;
          else left--;
        end
      end
      default: if (!bus.halt_req_i) m = M_RUN;
    endcase
  endtask

  // One clock: advance the model across the edge, apply new inputs, queue expectation.
  task automatic cycle(input logic r, input logic hq, input logic hx, input logic hr,
                       input logic ia, input logic [31:0] iaddr,
                       input logic jf, input logic [31:0] ja);
    @(posedge clk);
    model_edge();
    #1;
    rst = r;
    bus.halt_req_i = hq; bus.hold_ex_i = hx; bus.hold_rib_i = hr;
    bus.int_assert_i = ia; bus.int_addr_i = iaddr;
    bus.jump_flag_i = jf; bus.jump_addr_i = ja;
    last = model_out();
    sb.push_back(last);
    #1;
  endtask

  task automatic idle(input logic hq);
    cycle(1'b0, hq, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("sb_hold",   {29'd0, bus.hold_flag_o}, {29'd0, e.hold});
        chk("sb_jflag",  {31'd0, bus.jump_flag_o}, {31'd0, e.jflag});
        chk("sb_jaddr",  bus.jump_addr_o, e.addr);
        chk("sb_halted", {31'd0, bus.halted_o}, {31'd0, e.halted});
        chk("sb_cnt",    bus.hold_cnt_o, e.cnt);
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin : stim
    logic hq;
    bus.jump_flag_i = 0; bus.jump_addr_i = 0; bus.hold_ex_i = 0; bus.hold_rib_i = 0;
    bus.int_assert_i = 0; bus.int_addr_i = 0; bus.halt_req_i = 0;
    m = M_RUN; left = 0; m_cnt = 0;
    last.hold = 3'd0; last.jflag = 1'b0; last.addr = 32'd0; last.halted = 1'b0; last.cnt = 32'd0;

    // Reset, with redirect inputs active to show they are masked.
    cycle(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 32'h44, 1'b1, 32'h55);
    chk("rst_hold",  {29'd0, bus.hold_flag_o}, 32'd0);
    chk("rst_jflag", {31'd0, bus.jump_flag_o}, 32'd0);
    chk("rst_jaddr", bus.jump_addr_o, 32'd0);
    idle(1'b0);
    chk("rst_cnt",    bus.hold_cnt_o, 32'd0);
    chk("rst_halted", {31'd0, bus.halted_o}, 32'd0);

    // Jump: redirect cycle, one flush cycle, then free-running.
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 32'h100);
    chk("jmp_flag", {31'd0, bus.jump_flag_o}, 32'd1);
    chk("jmp_addr", bus.jump_addr_o, 32'h100);
    chk("jmp_hold", {29'd0, bus.hold_flag_o}, 32'd3);
    idle(1'b0);
    chk("flush_hold",  {29'd0, bus.hold_flag_o}, 32'd3);
    chk("flush_jaddr", bus.jump_addr_o, 32'd0);
    idle(1'b0);
    chk("post_flush_hold", {29'd0, bus.hold_flag_o}, 32'd0);

    // Interrupt wins over a simultaneous jump.
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h80, 1'b1, 32'h200);
    chk("prio_addr", bus.jump_addr_o, 32'h80);
    idle(1'b0);
    idle(1'b0);

    // Halt with EX busy for two cycles: 2 + DRAIN cycles of drain before halted.
    idle(1'b1);
    chk("halt_req_run_hold", {29'd0, bus.hold_flag_o}, 32'd0);
    for (int i = 0; i < 2; i++) begin
      cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
      chk("drain_ex_hold", {29'd0, bus.hold_flag_o}, 32'd3);
    end
    for (int i = 0; i < DRAIN; i++) begin
      idle(1'b1);
      chk("drain_hold",   {29'd0, bus.hold_flag_o}, 32'd1);
      chk("drain_halted", {31'd0, bus.halted_o}, 32'd0);
    end
    idle(1'b1);
    chk("halted",      {31'd0, bus.halted_o}, 32'd1);
    chk("halted_hold", {29'd0, bus.hold_flag_o}, 32'd3);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h80, 1'b0, 32'd0);
    chk("halted_int_ignored", {31'd0, bus.jump_flag_o}, 32'd0);
    idle(1'b0);
    idle(1'b0);
    chk("resume_halted", {31'd0, bus.halted_o}, 32'd0);
    chk("resume_hold",   {29'd0, bus.hold_flag_o}, 32'd0);

    // Saturation: preload the counter near full, then hold for three cycles.
    @(negedge clk);
    #1;
    force dut.u_hold_cnt.q = 32'hFFFF_FFFE;
    m_cnt = 32'hFFFF_FFFE;
    #1;
    release dut.u_hold_cnt.q;
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0);
    idle(1'b0);
    chk("sat_cnt", bus.hold_cnt_o, 32'hFFFF_FFFF);

    // Reset in the middle of a drain.
    idle(1'b1);
    idle(1'b1);
    idle(1'b1);
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 32'h300);
    chk("rst_mid_hold",  {29'd0, bus.hold_flag_o}, 32'd0);
    chk("rst_mid_jflag", {31'd0, bus.jump_flag_o}, 32'd0);
    idle(1'b0);
    chk("rst_mid_cnt",    bus.hold_cnt_o, 32'd0);
    chk("rst_mid_halted", {31'd0, bus.halted_o}, 32'd0);
    chk("rst_mid_out",    {29'd0, bus.hold_flag_o}, 32'd0);

    // Random traffic; halt request is a slowly toggling level.
    hq = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 19) == 0) hq = ~hq;
      cycle($urandom_range(0, 99) == 0, hq,
            $urandom_range(0, 4) == 0, $urandom_range(0, 4) == 0,
            $urandom_range(0, 19) == 0, $urandom,
            $urandom_range(0, 9) == 0, $urandom);
    end

    @(negedge clk);
    #1;
    chk("sb_drained", sb.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have parameter DRAIN_CYC, default 4, meaning cycles of Hold_Pc needed to empty IF/ID/EX before a debug halt completes.
REQ-002 SHALL have parameter FLUSH_CYC, default 1, meaning extra cycles Hold_Id is held after a redirect.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on rising edge.
REQ-004 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-005 SHALL have port jump_flag_i, input, 1: EX branch/jump taken.
REQ-006 SHALL have port jump_addr_i, input, 32: EX redirect target.
REQ-007 SHALL have port hold_ex_i, input, 1: EX multi-cycle op busy.
REQ-008 SHALL have port hold_rib_i, input, 1: bus arbiter has revoked the fetch grant.
REQ-009 SHALL have port int_assert_i, input, 1: CLINT interrupt redirect request.
REQ-010 SHALL have port int_addr_i, input, 32: interrupt vector / mret target.
REQ-011 SHALL have port halt_req_i, input, 1: JTAG halt request, level; deassert means resume.
REQ-012 SHALL have port hold_flag_o, output, 3: pipeline hold code (Hold_None=0, Hold_Pc=1, Hold_If=2, Hold_Id=3).
REQ-013 SHALL have port jump_flag_o, output, 1: PC redirect strobe.
REQ-014 SHALL have port jump_addr_o, output, 32: PC redirect target.
REQ-015 SHALL have port halted_o, output, 1: core halted, registered.
REQ-016 SHALL have port hold_cnt_o, output, 32: count of cycles with hold_flag_o != Hold_None.

Function
REQ-017 SHALL implement FSM states RUN, FLUSH, HALTING, HALTED.
REQ-018 SHALL drive jump_flag_o, jump_addr_o and hold_flag_o combinationally from state and inputs, with zero-cycle latency.
REQ-019 SHALL apply this redirect priority in RUN, FLUSH and HALTING: int_assert_i, then jump_flag_i.
REQ-020 SHALL, on redirect, output jump_flag_o=1 and hold_flag_o=Hold_Id; jump_addr_o = int_addr_i if int_assert_i, else jump_addr_i.
REQ-021 SHALL, on redirect from RUN or FLUSH, enter FLUSH with flush counter = FLUSH_CYC; a redirect in FLUSH reloads the counter.
REQ-022 SHALL, when FLUSH_CYC=0, return directly to RUN after a redirect.
REQ-023 SHALL, in FLUSH without redirect, output Hold_Id and decrement the counter; enter RUN on the cycle the counter reads 1.
REQ-024 SHALL, without redirect in RUN or FLUSH-exit, output Hold_Id if hold_ex_i, else Hold_Pc if hold_rib_i, else Hold_None.
REQ-025 SHALL, when jump_flag_o=0, output jump_addr_o=0.
REQ-026 SHALL, in RUN with halt_req_i=1 and no redirect, enter HALTING with drain counter = DRAIN_CYC.
REQ-027 SHALL keep a halt request pending while in FLUSH and act on it on FLUSH exit.
REQ-028 SHALL, in HALTING, output Hold_Pc, or Hold_Id if hold_ex_i.
REQ-029 SHALL, in HALTING, decrement the drain counter only on cycles where hold_ex_i=0 and there is no redirect; a redirect reloads it to DRAIN_CYC.
REQ-030 SHALL, in HALTING, enter HALTED when the drain counter reaches 0.
REQ-031 SHALL, in HALTING with halt_req_i=0, return to RUN next cycle.
REQ-032 SHALL, in HALTED, output Hold_Id and jump_flag_o=0, ignore int_assert_i, jump_flag_i and hold inputs, and set halted_o=1.
REQ-033 SHALL, in HALTED with halt_req_i=0, enter RUN next cycle and set halted_o=0 in the same edge.
REQ-034 SHALL increment hold_cnt_o by 1 each cycle hold_flag_o != Hold_None, saturating at 0xFFFF_FFFF with no wrap.

Reset
REQ-035 SHALL, with rst=1 at a clock edge, set state=RUN, counters=0, halted_o=0, hold_cnt_o=0.
REQ-036 SHALL, while rst=1, output hold_flag_o=Hold_None, jump_flag_o=0, jump_addr_o=0, regardless of other inputs.
REQ-037 SHALL abandon any in-progress FLUSH or HALTING when reset occurs mid-operation.

Structure
REQ-038 SHALL take the Hold_* codes and the FSM state enum from the shared defines package.
REQ-039 SHALL take the 32-bit bus widths (InstAddrBus) from the shared defines package.
REQ-040 SHALL implement hold_cnt_o in one sub-module, sat_cnt, a parameterised-width saturating counter with enable and synchronous clear.

Verification
REQ-041 SHALL test jump: jump_flag_i=1, jump_addr_i=0x100 for 1 cycle in RUN -> same cycle jump_flag_o=1, addr 0x100, Hold_Id; next cycle Hold_Id (FLUSH); then Hold_None.
REQ-042 SHALL test redirect priority: int_assert_i=1 (int_addr_i=0x80) and jump_flag_i=1 (0x200) in the same cycle -> jump_addr_o=0x80.
REQ-043 SHALL test halt drain: halt_req_i=1 in RUN, hold_ex_i high for 2 cycles -> halted_o rises after 2+4 cycles of hold; hold_flag_o=Hold_Id while halted.
REQ-044 SHALL test resume: halt_req_i=0 in HALTED -> next cycle halted_o=0 and Hold_None; int_assert_i pulsed while HALTED produces no jump_flag_o.
REQ-045 SHALL test saturation: force hold_cnt to 0xFFFF_FFFE, hold_rib_i=1 for 3 cycles -> hold_cnt_o=0xFFFF_FFFF, no wrap.
REQ-046 SHALL test reset mid-HALTING: rst=1 for 1 cycle -> state RUN, hold_cnt_o=0, halted_o=0, Hold_None.
